sqrt_module: RTL and testbench



---
 rtl/ecko_dsp_pkg.sv | 29 ++
 rtl/sqrt_step.sv | 36 +++
 rtl/sqrt_module.sv | 138 +++++++++++++
 tb/tb_sqrt_module.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecko_dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecko_dsp_pkg : shared constants, width helpers and FSM state type for the  |
// |                feature-extraction DSP blocks.                             |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package ecko_dsp_pkg;

  localparam int unsigned Q_DEFAULT   = 15;
  localparam int unsigned IN_W        = 32;
  localparam logic [15:0] Q15_SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_e;

  // Radicand holds the input shifted up by q, rounded up to an even width.
  function automatic int unsigned rad_w_f(input int unsigned q);
    return 2 * ((IN_W + q + 1) / 2);
  endfunction

  function automatic int unsigned res_w_f(input int unsigned q);
    return rad_w_f(q) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sqrt_step : one restoring square-root iteration (two radicand bits in,    |
// |             one root bit out).                                            |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module sqrt_step #(
  parameter int unsigned RES_W = 24
) (
  input  logic [RES_W+1:0] rem_i,
  input  logic [RES_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [RES_W+1:0] rem_o,
  output logic [RES_W-1:0] root_o
);

  localparam int unsigned EXT_W = RES_W + 4;

  logic [EXT_W-1:0] shifted_d;
  logic [EXT_W-1:0] trial_d;
  logic [RES_W+1:0] diff_d;
  logic             ge_d;

  // The shifted remainder needs two extra bits for the compare; the
  // difference always fits back into the remainder width.
  always_comb begin
    shifted_d = {rem_i, bits_i};
    trial_d   = {2'b00, root_i, 2'b01};
    ge_d      = (shifted_d >= trial_d);
    diff_d    = shifted_d[RES_W+1:0] - trial_d[RES_W+1:0];
    rem_o     = ge_d ? diff_d : shifted_d[RES_W+1:0];
    root_o    = {root_i[RES_W-2:0], ge_d};
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sqrt_module : bit-serial Q(Q) square root, 32-bit power in, 16-bit        |
// |               saturated magnitude out, constant latency.                  |
// | Build option: define SQRT_ROUND_EN for round-to-nearest (default floor).  |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
module sqrt_module
  import ecko_dsp_pkg::*;
#(
  parameter int unsigned Q = Q_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] data_in,
  input  logic               data_valid,
  output logic               in_ready,
  output logic signed [15:0] data_out,
  output logic               data_out_valid,
  output logic               neg_err,
  output logic               sat
);

  localparam int unsigned RAD_W = rad_w_f(Q);
  localparam int unsigned RES_W = res_w_f(Q);
  localparam int unsigned REM_W = RES_W + 2;
  localparam int unsigned CNT_W = $clog2(RES_W);

  sqrt_state_e      state_q;
  logic [RAD_W-1:0] rad_q;
  logic [REM_W-1:0] rem_q;
  logic [RES_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_pend_q;
  logic             in_ready_q;
  logic [15:0]      data_out_q;
  logic             valid_q;
  logic             neg_err_q;
  logic             sat_q;

  logic [RAD_W-1:0] rad_load_d;
  logic [REM_W-1:0] step_rem_d;
  logic [RES_W-1:0] step_root_d;
  logic [RES_W:0]   final_root_d;
  logic             final_sat_d;
  logic [15:0]      final_out_d;

  always_comb begin
    rad_load_d = '0;
    if (!data_in[31]) begin
      rad_load_d = RAD_W'($unsigned(data_in)) << Q;
    end
  end

  sqrt_step #(
    .RES_W (RES_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RAD_W-1 -: 2]),
    .rem_o  (step_rem_d),
    .root_o (step_root_d)
  );

  // The last step's outputs feed the result directly, so no extra cycle is spent.
  always_comb begin
    final_root_d = {1'b0, step_root_d};
`ifdef SQRT_ROUND_EN
    if (step_rem_d > REM_W'(step_root_d)) begin
      final_root_d = final_root_d + (RES_W+1)'(1);
    end
`endif
    final_sat_d = (final_root_d > (RES_W+1)'(Q15_SAT_MAX));
    final_out_d = final_sat_d ? Q15_SAT_MAX : final_root_d[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      in_ready_q <= 1'b1;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      neg_err_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_valid) begin
            rad_q      <= rad_load_d;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= CNT_W'(RES_W - 1);
            neg_pend_q <= data_in[31];
            in_ready_q <= 1'b0;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          rad_q  <= rad_q << 2;
          rem_q  <= step_rem_d;
          root_q <= step_root_d;
          if (cnt_q == '0) begin
            data_out_q <= final_out_d;
            sat_q      <= final_sat_d;
            neg_err_q  <= neg_pend_q;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign data_out       = $signed(data_out_q);
  assign data_out_valid = valid_q;
  assign neg_err        = neg_err_q;
  assign sat            = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sqrt_module : randomized scoreboard bench for sqrt_module with an      |
// |                  arithmetic (binary-search) square-root reference.        |
// | Revision       : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_sqrt_module;

  localparam int LAT_EDGES  = 24;  // valid visible after edge 24 counted from the accept edge
  localparam int BUSY_CYC   = 24;  // in_ready low from the accept edge through the valid cycle
  localparam int PERIOD_CYC = 26;
`ifdef SQRT_ROUND_EN
  localparam logic [15:0] EXP_SQRT3 = 16'd314;
`else
  localparam logic [15:0] EXP_SQRT3 = 16'd313;
`endif

  logic               clk        = 1'b0;
  logic               rst_n      = 1'b0;
  logic               data_valid = 1'b0;
  logic signed [31:0] data_in    = '0;
  logic               in_ready;
  logic signed [15:0] data_out;
  logic               data_out_valid;
  logic               neg_err;
  logic               sat;

  sqrt_module dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .in_ready       (in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .neg_err        (neg_err),
    .sat            (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic        sat;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks    = 0;
  int   failures  = 0;
  int   last_acc  = -1000;
  bit   busy      = 1'b0;
  bit   b2b_mode  = 1'b0;
  int   prev_vcyc = -1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur as required at cycle %0d", nm, cyc);
  endfunction

  // Reference: largest r with r*r <= x*2^15, optional round, then Q15 clip.
  function automatic void model(input logic signed [31:0] x, output logic [15:0] o,
                                output logic s, output logic n);
    longint rv, lo, hi, mid, root;
    o = '0; s = 1'b0; n = 1'b0;
    if (x < 0) begin
      n = 1'b1;
      return;
    end
    rv = longint'(x) * 64'sd32768;
    lo = 0;
    hi = 64'sd1 << 24;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= rv) lo = mid;
      else hi = mid;
    end
    root = lo;
`ifdef SQRT_ROUND_EN
    if (rv > root * root + root) root = root + 1;
`endif
    if (root > 32767) begin
      o = 16'h7FFF;
      s = 1'b1;
    end else begin
      o = 16'(root);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      chk("in_ready", longint'(in_ready), (busy && (cyc - last_acc) <= BUSY_CYC) ? 0 : 1);
      if (data_out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: data_out_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("data_out", longint'($unsigned(data_out)), longint'(e.out));
          chk("sat", longint'(sat), longint'(e.sat));
          chk("neg_err", longint'(neg_err), longint'(e.neg));
          chk("latency", cyc - e.acc, LAT_EDGES);
          if (b2b_mode) begin
            if (prev_vcyc >= 0) chk("b2b_spacing", cyc - prev_vcyc, PERIOD_CYC);
            prev_vcyc = cyc;
          end
        end
      end else if (sbq.size() > 0 && (cyc - sbq[0].acc) > LAT_EDGES + 10) begin
        e = sbq.pop_front();
        fail_now("missing_valid");
      end
    end
  end

  task automatic send(input logic signed [31:0] x, input logic [15:0] eo,
                      input logic es, input logic en);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    data_in    = x;
    data_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      data_valid = 1'b0;
      return;
    end
    e.out = eo; e.sat = es; e.neg = en; e.acc = cyc + 1;
    sbq.push_back(e);
    last_acc = cyc + 1;
    busy     = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = $urandom;
  endtask

  task automatic send_m(input logic signed [31:0] x);
    logic [15:0] o;
    logic        s, n;
    model(x, o, s, n);
    send(x, o, s, n);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() > 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  // data_valid held high while data_in changes every cycle.
  task automatic b2b(input int n);
    int          got, w;
    logic [15:0] o;
    logic        s, ng;
    exp_t        e;
    drain();
    prev_vcyc = -1;
    b2b_mode  = 1'b1;
    got = 0;
    w   = 0;
    while (got < n && w < n * PERIOD_CYC + 100) begin
      @(negedge clk);
      data_in    = $urandom;
      data_valid = 1'b1;
      if (in_ready) begin
        model(data_in, o, s, ng);
        e.out = o; e.sat = s; e.neg = ng; e.acc = cyc + 1;
        sbq.push_back(e);
        last_acc = cyc + 1;
        busy     = 1'b1;
        got++;
      end
      w++;
    end
    if (got < n) fail_now("b2b_accepts");
    @(negedge clk);
    data_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;
  endtask

  initial begin : stim
    logic signed [31:0] x;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data_out", longint'($unsigned(data_out)), 0);
    chk("rst_valid", longint'(data_out_valid), 0);
    chk("rst_neg_err", longint'(neg_err), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_in_ready", longint'(in_ready), 1);

    send(32'sd8192, 16'd16384, 1'b0, 1'b0);
    send(32'sd3, EXP_SQRT3, 1'b0, 1'b0);
    send(32'sd2, 16'd256, 1'b0, 1'b0);
    send(32'sd0, 16'd0, 1'b0, 1'b0);
    send(32'sd32768, 16'd32767, 1'b1, 1'b0);
    send(32'sh7FFFFFFF, 16'd32767, 1'b1, 1'b0);
    send(-32'sd5, 16'd0, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       x = $signed(32'($urandom_range(0, 255)));
        1:       x = $urandom;
        2:       x = $signed(32'($urandom_range(0, 65535)));
        3:       x = $signed($urandom & 32'h7FFF_FFFF);
        default: x = -$signed(32'($urandom_range(1, 1000)));
      endcase
      send_m(x);
    end

    b2b(5);

    // Abort a calculation with an asynchronous reset about ten CALC cycles in.
    drain();
    send(32'sd32768, 16'd32767, 1'b1, 1'b0);
    drain();
    send_m(32'sd12345);
    while (cyc < last_acc + 10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", longint'($unsigned(data_out)), 0);
    chk("arst_valid", longint'(data_out_valid), 0);
    chk("arst_sat", longint'(sat), 0);
    chk("arst_neg_err", longint'(neg_err), 0);
    chk("arst_in_ready", longint'(in_ready), 1);
    sbq.delete();
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(32'sd8192, 16'd16384, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
